// File: rtl/spi_slave_if_if.sv
// Signal bundle between the SPI slave front end and its master/RAM side:
// serial pins plus the parallel command/read-data handshake.
interface spi_slave_if_if #(parameter int ADDR_SIZE = 8);
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;
  logic [ADDR_SIZE+1:0] rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] tx_data;
  logic                 tx_valid;

  modport slave  (input  SS_n, MOSI, tx_data, tx_valid,
                  output MISO, rx_data, rx_valid);
  modport master (output SS_n, MOSI, tx_data, tx_valid,
                  input  MISO, rx_data, rx_valid);
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front end for the dual-port RAM: deserialises MOSI frames into
// {op, data} commands and serialises RAM read data back out on MISO.
module spi_slave_if #(
  parameter int ADDR_SIZE = 8
) (
  input  logic           clk,
  input  logic           rst,
  spi_slave_if_if.slave  bus
);

  localparam int FRAME_W  = ADDR_SIZE + 2;
  localparam int RX_CNT_W = $clog2(FRAME_W);
  localparam int TX_CNT_W = $clog2(ADDR_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  // Sub-phase inside a payload state: shifting in, waiting for RAM, shifting out, finished.
  typedef enum logic [1:0] {
    PH_RX   = 2'd0,
    PH_WAIT = 2'd1,
    PH_TX   = 2'd2,
    PH_DONE = 2'd3
  } phase_t;

  state_t                state_r;
  phase_t                phase_r;
  logic [RX_CNT_W-1:0]   bit_cnt_r;
  logic [TX_CNT_W-1:0]   tx_cnt_r;
  logic [FRAME_W-2:0]    rx_sh_r;
  logic [ADDR_SIZE-1:0]  tx_sh_r;
  logic [FRAME_W-1:0]    rx_data_r;
  logic                  rx_valid_r;
  logic                  miso_r;
  logic                  rd_addr_flag_r;

  function automatic state_t cmd_state(input logic cmd_bit, input logic rd_flag);
    state_t nxt;
    if (!cmd_bit)     nxt = WRITE;
    else if (rd_flag) nxt = READ_DATA;
    else              nxt = READ_ADD;
    return nxt;
  endfunction

  // Frame sequencer: command decode, payload shift-in, read-data shift-out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      phase_r        <= PH_RX;
      bit_cnt_r      <= {RX_CNT_W{1'b0}};
      tx_cnt_r       <= {TX_CNT_W{1'b0}};
      rx_sh_r        <= {(FRAME_W-1){1'b0}};
      tx_sh_r        <= {ADDR_SIZE{1'b0}};
      rx_data_r      <= {FRAME_W{1'b0}};
      rx_valid_r     <= 1'b0;
      miso_r         <= 1'b0;
      rd_addr_flag_r <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      // Deselect wins over everything, including the final payload bit.
      if (state_r != IDLE && bus.SS_n) begin
        state_r   <= IDLE;
        phase_r   <= PH_RX;
        bit_cnt_r <= {RX_CNT_W{1'b0}};
        tx_cnt_r  <= {TX_CNT_W{1'b0}};
        miso_r    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            phase_r   <= PH_RX;
            bit_cnt_r <= {RX_CNT_W{1'b0}};
            tx_cnt_r  <= {TX_CNT_W{1'b0}};
            miso_r    <= 1'b0;
            if (!bus.SS_n) state_r <= CHK_CMD;
            else           state_r <= IDLE;
          end
          CHK_CMD: begin
            state_r <= cmd_state(bus.MOSI, rd_addr_flag_r);
          end
          WRITE, READ_ADD, READ_DATA: begin
            case (phase_r)
              PH_RX: begin
                rx_sh_r <= {rx_sh_r[FRAME_W-3:0], bus.MOSI};
                if (bit_cnt_r == RX_CNT_W'(FRAME_W - 1)) begin
                  rx_data_r  <= {rx_sh_r, bus.MOSI};
                  rx_valid_r <= 1'b1;
                  bit_cnt_r  <= {RX_CNT_W{1'b0}};
                  if (state_r == READ_ADD) rd_addr_flag_r <= 1'b1;
                  else                     rd_addr_flag_r <= rd_addr_flag_r;
                  if (state_r == READ_DATA) phase_r <= PH_WAIT;
                  else                      phase_r <= PH_DONE;
                end else begin
                  bit_cnt_r <= bit_cnt_r + RX_CNT_W'(1);
                end
              end
              PH_WAIT: begin
                if (bus.tx_valid) begin
                  miso_r   <= bus.tx_data[ADDR_SIZE-1];
                  tx_sh_r  <= {bus.tx_data[ADDR_SIZE-2:0], 1'b0};
                  tx_cnt_r <= TX_CNT_W'(1);
                  phase_r  <= PH_TX;
                end else begin
                  miso_r <= 1'b0;
                end
              end
              PH_TX: begin
                if (tx_cnt_r == TX_CNT_W'(ADDR_SIZE)) begin
                  miso_r         <= 1'b0;
                  rd_addr_flag_r <= 1'b0;
                  phase_r        <= PH_DONE;
                end else begin
                  miso_r   <= tx_sh_r[ADDR_SIZE-1];
                  tx_sh_r  <= {tx_sh_r[ADDR_SIZE-2:0], 1'b0};
                  tx_cnt_r <= tx_cnt_r + TX_CNT_W'(1);
                end
              end
              PH_DONE: begin
                miso_r <= 1'b0;
              end
              default: begin
                phase_r <= PH_DONE;
                miso_r  <= 1'b0;
              end
            endcase
          end
          default: begin
            state_r <= IDLE;
            miso_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.MISO     = miso_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;

endmodule
